// File: rtl/resp_order_merger_pkg.sv
// Shared types for the response order merger and the request router.
// Holds the destination encoding and the peripheral address decode.
package resp_order_merger_pkg;

   typedef enum logic {
      DEST_MEM    = 1'b0,
      DEST_PERIPH = 1'b1
   } dest_e;

   localparam logic [3:0] PERIPH_ADDR_PREFIX = 4'hF;
   localparam int unsigned MSG_W = 32;

   typedef logic [MSG_W-1:0] msg_t;

   // Router-side decode of addr[31:28] into a destination.
   function automatic dest_e addr_dest(input logic [3:0] addr_hi);
      return (addr_hi == PERIPH_ADDR_PREFIX) ? DEST_PERIPH : DEST_MEM;
   endfunction

endpackage

// File: rtl/resp_order_merger_if.sv
// MemNetResp valid/ready response channel.
// server: consumes val/msg, drives rdy. client: drives val/msg, consumes rdy.
interface resp_order_merger_if;
   import resp_order_merger_pkg::*;

   logic val;
   logic rdy;
   msg_t msg;

   modport server (input val, input msg, output rdy);
   modport client (output val, output msg, input rdy);

endinterface

// File: rtl/resp_order_merger_dest_fifo.sv
// In-order destination tracker: p_depth x 1-bit FIFO of dest_e.
// Ports: push/push_dest, pop, head, full, empty, count.
module resp_order_merger_dest_fifo
   import resp_order_merger_pkg::*;
#(
   parameter  int unsigned p_depth = 4,
   localparam int unsigned PW      = $clog2(p_depth),
   localparam int unsigned CW      = $clog2(p_depth + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  dest_e         push_dest,
   input  logic          pop,
   output dest_e         head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [p_depth-1:0] slot_q, slot_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               do_push, do_pop;

   assign full  = (count_q == CW'(p_depth));
   assign empty = (count_q == '0);
   assign head  = dest_e'(slot_q[rd_ptr_q]);
   assign count = count_q;

   // Pointers wrap naturally since p_depth is a power of two.
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      slot_d   = slot_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         slot_d[wr_ptr_q] = push_dest;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         slot_q   <= slot_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/resp_order_merger.sv
// Merges memory/peripheral responses back onto one channel in request order.
// Ports: clk, rst, req_xfer/req_periph, track_rdy, outstanding, mem_resp, periph_resp, resp.
module resp_order_merger
   import resp_order_merger_pkg::*;
#(
   parameter  int unsigned p_depth = 4,
   localparam int unsigned CW      = $clog2(p_depth + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_xfer,
   input  logic                       req_periph,
   output logic                       track_rdy,
   output logic [CW-1:0]              outstanding,
   resp_order_merger_if.server        mem_resp,
   resp_order_merger_if.server        periph_resp,
   resp_order_merger_if.client        resp
);

   dest_e head;
   logic  full;
   logic  empty;
   logic  fire;

   resp_order_merger_dest_fifo #(
      .p_depth (p_depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_xfer),
      .push_dest (dest_e'(req_periph)),
      .pop       (fire),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (outstanding)
   );

   // Registered state only: no path from resp.rdy to track_rdy.
   assign track_rdy = ~full & ~rst;
   assign fire      = resp.val & resp.rdy;

   // Only the head destination may talk; the other source is held off.
   always_comb begin
      resp.val        = 1'b0;
      resp.msg        = '0;
      mem_resp.rdy    = 1'b0;
      periph_resp.rdy = 1'b0;
      if (!empty) begin
         unique case (head)
            DEST_PERIPH: begin
               resp.val        = periph_resp.val;
               resp.msg        = periph_resp.msg;
               periph_resp.rdy = resp.rdy;
            end
            default: begin
               resp.val     = mem_resp.val;
               resp.msg     = mem_resp.msg;
               mem_resp.rdy = resp.rdy;
            end
         endcase
      end
   end

   a_push_full : assert property (
      @(posedge clk) disable iff (rst) !(req_xfer && full)
   );

   a_val_empty : assert property (
      @(posedge clk) disable iff (rst)
      !((mem_resp.val || periph_resp.val) && empty)
   );

endmodule
